// File: rtl/gpu_timing_pkg.sv
// Shared VGA 640x480@60 (half pixel rate) raster constants and the decoded raster record.
// Latency: n/a (definitions only); backpressure: none.
package gpu_timing_pkg;

  localparam int H_VISIBLE     = 320;
  localparam int H_FRONT       = 8;
  localparam int H_SYNC        = 48;
  localparam int H_BACK        = 24;
  localparam int H_TOTAL       = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int H_SYNC_START  = H_VISIBLE + H_FRONT;
  localparam int H_SYNC_END    = H_SYNC_START + H_SYNC;

  localparam int V_VISIBLE     = 480;
  localparam int V_FRONT       = 10;
  localparam int V_SYNC        = 2;
  localparam int V_BACK        = 33;
  localparam int V_TOTAL       = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int V_SYNC_START  = V_VISIBLE + V_FRONT;
  localparam int V_SYNC_END    = V_SYNC_START + V_SYNC;

  localparam int GAME_X_OFFSET = 32;
  localparam int GAME_W        = 256;
  localparam int GAME_H        = 240;

  typedef struct packed {
    logic [7:0] current_x;
    logic [7:0] current_y;
    logic       in_game;
    logic       visible;
    logic       writable;
    logic       hsync;
    logic       vsync;
    logic       vblank_irq;
  } raster_t;

  localparam raster_t RASTER_RESET = '{
    current_x:  8'd0,
    current_y:  8'd0,
    in_game:    1'b0,
    visible:    1'b0,
    writable:   1'b0,
    hsync:      1'b1,
    vsync:      1'b1,
    vblank_irq: 1'b0
  };

endpackage

// File: rtl/wrap_counter_m.sv
// Modulo-N up counter advancing on inc; wrap flags the inc that returns it to zero.
// Latency: count updates one clock after inc, wrap is combinational; backpressure: none.
module wrap_counter_m
  import gpu_timing_pkg::*;
#(
  parameter int MODULUS = H_TOTAL,
  parameter int W       = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(MODULUS - 1);

  assign wrap = inc && (count == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/video_timing.sv
// Raster timing generator: h/v counters decoded into game-window coords, syncs, blank and irq.
// Latency: outputs are a registered decode, one clock behind the counters; backpressure: none (free-running).
module video_timing
  import gpu_timing_pkg::*;
#(
  parameter int H_VISIBLE     = gpu_timing_pkg::H_VISIBLE,
  parameter int H_FRONT       = gpu_timing_pkg::H_FRONT,
  parameter int H_SYNC        = gpu_timing_pkg::H_SYNC,
  parameter int H_BACK        = gpu_timing_pkg::H_BACK,
  parameter int V_VISIBLE     = gpu_timing_pkg::V_VISIBLE,
  parameter int V_FRONT       = gpu_timing_pkg::V_FRONT,
  parameter int V_SYNC        = gpu_timing_pkg::V_SYNC,
  parameter int V_BACK        = gpu_timing_pkg::V_BACK,
  parameter int GAME_X_OFFSET = gpu_timing_pkg::GAME_X_OFFSET
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] current_x,
  output logic [7:0] current_y,
  output logic       in_game,
  output logic       visible,
  output logic       writable,
  output logic       hsync,
  output logic       vsync,
  output logic       vblank_irq
);

  localparam int LINE_CLKS  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int FRAME_ROWS = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [8:0] H_VIS_END  = 9'(H_VISIBLE);
  localparam logic [8:0] H_SS       = 9'(H_VISIBLE + H_FRONT);
  localparam logic [8:0] H_SE       = 9'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [8:0] GAME_X0    = 9'(GAME_X_OFFSET);
  localparam logic [8:0] GAME_X1    = 9'(GAME_X_OFFSET + GAME_W);
  localparam logic [9:0] V_VIS_END  = 10'(V_VISIBLE);
  localparam logic [9:0] V_SS       = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] V_SE       = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [8:0] hcount;
  logic [9:0] vcount;
  logic       h_wrap;
  logic       v_wrap_unused;
  logic       v_active;
  raster_t    raster_d;
  raster_t    raster_q;

  wrap_counter_m #(.MODULUS(LINE_CLKS), .W(9)) u_hcount (
    .clk   (clk),
    .rst   (rst),
    .inc   (1'b1),
    .count (hcount),
    .wrap  (h_wrap)
  );

  wrap_counter_m #(.MODULUS(FRAME_ROWS), .W(10)) u_vcount (
    .clk   (clk),
    .rst   (rst),
    .inc   (h_wrap),
    .count (vcount),
    .wrap  (v_wrap_unused)
  );

  always_comb begin
    raster_d   = RASTER_RESET;
    v_active   = (vcount < V_VIS_END);
    raster_d.visible    = (hcount < H_VIS_END) && v_active;
    raster_d.in_game    = (hcount >= GAME_X0) && (hcount < GAME_X1) && v_active;
    raster_d.current_x  = raster_d.in_game ? 8'(hcount - GAME_X0) : 8'd0;
    // each game row is drawn on two consecutive lines
    raster_d.current_y  = v_active ? vcount[8:1] : 8'd0;
    raster_d.writable   = !v_active;
    raster_d.hsync      = !((hcount >= H_SS) && (hcount < H_SE));
    raster_d.vsync      = !((vcount >= V_SS) && (vcount < V_SE));
    raster_d.vblank_irq = (hcount == 9'd0) && (vcount == V_VIS_END);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raster_q <= RASTER_RESET;
    end else begin
      raster_q <= raster_d;
    end
  end

  assign current_x  = raster_q.current_x;
  assign current_y  = raster_q.current_y;
  assign in_game    = raster_q.in_game;
  assign visible    = raster_q.visible;
  assign writable   = raster_q.writable;
  assign hsync      = raster_q.hsync;
  assign vsync      = raster_q.vsync;
  assign vblank_irq = raster_q.vblank_irq;

endmodule

// File: tb/tb_video_timing.sv
// Bench for video_timing: full-size instance for line/point decode, short-frame instance for frame-level behaviour.
module tb_video_timing;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic [7:0] x, y, sx, sy;
  logic ig, vis, wr, hs, vs, irq;
  logic sig, svis, swr, shs, svs, sirq;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int cyc;

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  video_timing dut (
    .clk(clk), .rst(rst),
    .current_x(x), .current_y(y), .in_game(ig), .visible(vis),
    .writable(wr), .hsync(hs), .vsync(vs), .vblank_irq(irq)
  );

  // Short frame: 20 visible + 2 front + 2 sync + 3 back = 27 lines, 10800 clocks.
  video_timing #(.V_VISIBLE(20), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)) dut_s (
    .clk(clk), .rst(rst),
    .current_x(sx), .current_y(sy), .in_game(sig), .visible(svis),
    .writable(swr), .hsync(shs), .vsync(svs), .vblank_irq(sirq)
  );

  typedef struct {
    int h; int v;
    int ex; int ey;
    bit eig; bit evis; bit ewr; bit ehs; bit evs; bit eirq;
  } vec_t;

  vec_t tbl[20];

  task automatic check(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  function automatic int pk(input logic [7:0] px, input logic [7:0] py, input logic pig,
                            input logic pvis, input logic pwr, input logic phs,
                            input logic pvs, input logic pirq);
    logic [21:0] p;
    p = {px, py, pig, pvis, pwr, phs, pvs, pirq};
    return int'(p);
  endfunction

  function automatic int act_main();
    return pk(x, y, ig, vis, wr, hs, vs, irq);
  endfunction

  function automatic int act_small();
    return pk(sx, sy, sig, svis, swr, shs, svs, sirq);
  endfunction

  // Outputs after the n-th clock following reset release decode linear position n-1.
  task automatic run_vec(input vec_t t);
    int target;
    int g;
    target = t.v * 400 + t.h + 1;
    g = 0;
    if (cyc > target) begin
      check($sformatf("vec_order h=%0d v=%0d", t.h, t.v), cyc, target);
      return;
    end
    while (cyc != target && g < 100000) begin
      @(negedge clk);
      g++;
    end
    if (cyc != target) begin
      check($sformatf("vec_timeout h=%0d v=%0d", t.h, t.v), cyc, target);
      return;
    end
    check($sformatf("vec h=%0d v=%0d", t.h, t.v), act_main(),
          pk(8'(t.ex), 8'(t.ey), t.eig, t.evis, t.ewr, t.ehs, t.evs, t.eirq));
  endtask

  initial begin
    int rst_val, zero_val;
    bit found;
    bit prev_wr, prev_ig;
    int wr_c, ig_c, vis_c, hs_c, vs_c, irq_c, ovl_c, first_vs, k, irq_after;

    //            h    v    x    y  ig vis wr hs vs irq
    tbl[0]  = '{  0,   0,   0,   0, 0, 1, 0, 1, 1, 0};
    tbl[1]  = '{ 31,   0,   0,   0, 0, 1, 0, 1, 1, 0};
    tbl[2]  = '{ 32,   0,   0,   0, 1, 1, 0, 1, 1, 0};
    tbl[3]  = '{ 33,   0,   1,   0, 1, 1, 0, 1, 1, 0};
    tbl[4]  = '{287,   0, 255,   0, 1, 1, 0, 1, 1, 0};
    tbl[5]  = '{288,   0,   0,   0, 0, 1, 0, 1, 1, 0};
    tbl[6]  = '{319,   0,   0,   0, 0, 1, 0, 1, 1, 0};
    tbl[7]  = '{320,   0,   0,   0, 0, 0, 0, 1, 1, 0};
    tbl[8]  = '{327,   0,   0,   0, 0, 0, 0, 1, 1, 0};
    tbl[9]  = '{328,   0,   0,   0, 0, 0, 0, 0, 1, 0};
    tbl[10] = '{375,   0,   0,   0, 0, 0, 0, 0, 1, 0};
    tbl[11] = '{376,   0,   0,   0, 0, 0, 0, 1, 1, 0};
    tbl[12] = '{399,   0,   0,   0, 0, 0, 0, 1, 1, 0};
    tbl[13] = '{  0,   1,   0,   0, 0, 1, 0, 1, 1, 0};
    tbl[14] = '{100,   1,  68,   0, 1, 1, 0, 1, 1, 0};
    tbl[15] = '{100,   2,  68,   1, 1, 1, 0, 1, 1, 0};
    tbl[16] = '{200,   3, 168,   1, 1, 1, 0, 1, 1, 0};
    tbl[17] = '{ 50,  40,  18,  20, 1, 1, 0, 1, 1, 0};
    tbl[18] = '{287,  75, 255,  37, 1, 1, 0, 1, 1, 0};
    tbl[19] = '{350,  75,   0,  37, 0, 0, 0, 0, 1, 0};

    rst_val  = pk(8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    zero_val = pk(8'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);

    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_main", act_main(), rst_val);
    check("reset_small", act_small(), rst_val);
    rst = 1'b0;

    foreach (tbl[i]) run_vec(tbl[i]);

    // Frame-level behaviour on the short-frame instance, starting at a vblank pulse.
    found   = 1'b0;
    prev_wr = 1'b1;
    for (int i = 0; i < 12000 && !found; i++) begin
      @(negedge clk);
      if (sirq) found = 1'b1;
      else      prev_wr = swr;
    end
    check("irq_seen", int'(found), 1);
    if (found) begin
      check("irq_writable_now", int'(swr), 1);
      check("irq_writable_before", int'(prev_wr), 0);
      check("irq_in_game", int'(sig), 0);
      check("irq_current_y", int'(sy), 0);

      wr_c = int'(swr); ig_c = int'(sig); vis_c = int'(svis);
      hs_c = int'(!shs); vs_c = int'(!svs); irq_c = int'(sirq);
      ovl_c = int'(sig && swr); first_vs = -1; k = 0; prev_ig = sig;
      for (int t = 1; t < 10800; t++) begin
        @(negedge clk);
        wr_c  += int'(swr);
        ig_c  += int'(sig);
        vis_c += int'(svis);
        hs_c  += int'(!shs);
        vs_c  += int'(!svs);
        irq_c += int'(sirq);
        ovl_c += int'(sig && swr);
        if (!svs && first_vs < 0) first_vs = t;
        if (sig && !prev_ig) begin
          check($sformatf("row%0d_current_y", k), int'(sy), k / 2);
          check($sformatf("row%0d_x_at_entry", k), int'(sx), 0);
          k++;
        end
        prev_ig = sig;
      end
      @(negedge clk);
      check("irq_period", int'(sirq), 1);
      check("writable_clocks", wr_c, 2800);
      check("in_game_clocks", ig_c, 5120);
      check("visible_clocks", vis_c, 6400);
      check("hsync_low_clocks", hs_c, 1296);
      check("vsync_low_clocks", vs_c, 800);
      check("vsync_start_offset", first_vs, 800);
      check("irq_pulses_per_frame", irq_c, 1);
      check("in_game_while_writable", ovl_c, 0);
      check("game_rows", k, 20);
    end

    // Reset asserted on the irq cycle: the pulse must vanish immediately.
    rst = 1'b1;
    #1;
    check("midframe_reset_small", act_small(), rst_val);
    check("midframe_reset_main", act_main(), rst_val);
    repeat (2) @(negedge clk);
    check("held_reset_main", act_main(), rst_val);
    rst = 1'b0;
    @(negedge clk);
    check("first_decode_main", act_main(), zero_val);
    check("first_decode_small", act_small(), zero_val);
    run_vec(tbl[2]);
    run_vec(tbl[4]);
    irq_after = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      irq_after += int'(sirq);
    end
    check("no_irq_after_reset", irq_after, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/video_timing.md
# video_timing

Generates the 12.5875 MHz raster timing for the GPU: horizontal/vertical counters for a 640x480@60 VGA frame at half pixel rate, the 256x240 game-window coordinates (`current_x`, `current_y`) consumed by the background and foreground stages, the VRAM `writable` window, sync pulses for the DAC, and a vblank interrupt pulse to the CPU. It sits at the head of the GPU pixel pipeline.

## Interface
- `H_VISIBLE`, 320, visible clocks per line
- `H_FRONT`, 8, front porch clocks
- `H_SYNC`, 48, hsync clocks
- `H_BACK`, 24, back porch clocks (line total 400)
- `V_VISIBLE`, 480, visible lines
- `V_FRONT`, 10; `V_SYNC`, 2; `V_BACK`, 33 (frame total 525)
- `GAME_X_OFFSET`, 32, first h-count inside game window
- `clk` in 1: pixel clock, 12.5875 MHz
- `rst` in 1: asynchronous, active-high reset
- `current_x` out 8: game column 0..255
- `current_y` out 8: game row 0..239
- `in_game` out 1: raster inside 256x240 window
- `visible` out 1: raster inside 320x480 active area
- `writable` out 1: vertical blank, VRAM writes permitted
- `hsync`, `vsync` out 1: active-low sync
- `vblank_irq` out 1: one-cycle pulse at vblank start

## Operation
- Internal `hcount` 0..399, `vcount` 0..524. `hcount` increments every clock; at 399 wraps to 0 and `vcount` increments; `vcount` at 524 with `hcount`=399 wraps to 0.
- All outputs are registered decodes of the (hcount, vcount) pair held in the same cycle; outputs lag counters by one clock, mutually consistent.
- `visible` = hcount<320 && vcount<480.
- `in_game` = 32<=hcount<288 && vcount<480.
- `current_x` = (hcount-32)[7:0] when in game window, else 0.
- `current_y` = vcount[8:1] when vcount<480, else 0 (each game row is drawn on two lines).
- `writable` = vcount>=480.
- `hsync` low for hcount 328..375; `vsync` low for vcount 490..491.
- `vblank_irq` high exactly when decoded pair is (0,480).
- No state machine beyond the two wrapping counters; no stall or enable input.

## Timing
- Reset (async assert): hcount=0, vcount=0; outputs current_x=0, current_y=0, in_game=0, visible=0, writable=0, hsync=1, vsync=1, vblank_irq=0.
- First rising edge after deassert: outputs decode (0,0) -> visible=1, in_game=0, writable=0.
- Line period 400 clocks, frame period 210000 clocks; `vblank_irq` period 210000 clocks.
- `in_game` high for 256 consecutive clocks per line on 480 lines; `current_x` increments 0..255 across them.
- `writable` rises on decode of (0,480), falls on decode of (0,0); high for 45*400 = 18000 clocks.
- Reset mid-frame: immediate return to reset values; no partial irq pulse survives.
- Count arithmetic 9-bit (h) and 10-bit (v); `current_x` subtraction truncated to 8 bits.

## Structure
- Timing constants (totals, sync start/end, game offset) live in shared `gpu_timing_pkg`; foreground/background import the 256x240 bounds from it.
- One natural sub-module: `wrap_counter_m` (parameterised modulus, `inc`, `wrap` output), instantiated for h and v with h `wrap` driving v `inc`.

## Test plan
- Assert `rst` mid-line, release -> all outputs equal reset values, then (0,0) decode one clock later with visible=1.
- Run one line -> `in_game` high exactly 256 clocks; `current_x` sees 0 at h=32 decode, 255 at h=287; hsync low 48 clocks starting at h=328.
- Run one frame -> `current_y` steps 0,0,1,1,...,239,239 per line; vsync low for 800 clocks starting at line 490.
- Measure across two frames -> `vblank_irq` pulses one clock each, 210000 clocks apart, coinciding with `writable` rising.
- `writable` duty -> high 18000 clocks, low 192000 clocks per frame; `in_game`=0 whenever writable=1.
- Hook to foreground with object at (0,0) -> its pixels appear only when current_x<8, current_y<8 and in_game=1.
